sram10t_2r1w: RTL and testbench

Behavioural model of a 4096 x 1-bit 10T SRAM macro with two independent read ports and one write port. It shares the address-1 port between reading and writing. The block is the storage leaf of the memory subsystem and is driven by a single controller supplying addresses, a read/write select and a device enable.

---
 rtl/sram10t_pkg.sv | 12 +
 rtl/sram10t_decoder.sv | 18 +
 rtl/sram10t_2r1w.sv | 71 +++++++
 tb/tb_sram10t_2r1w.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram10t_pkg.sv
// Shared constants for the 10T 2R1W bit-cell macro: geometry and the
// encoding of the read/write select.
package sram10t_pkg;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  // RdWr encoding: high selects a read of both ports, low a write on port 1
  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

endpackage

// File: rtl/sram10t_decoder.sv
// ADDR_W-to-DEPTH one-hot word-line decoder. With en low every word line
// stays low, so a disabled port neither reads nor writes any cell.
module sram10t_decoder #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DEPTH-1:0]  sel
);

  // Raise exactly one word line when enabled
  always_comb begin
    sel = '0;
    if (en) sel[addr] = 1'b1;
  end

endmodule

// File: rtl/sram10t_2r1w.sv
// 4096 x 1 10T SRAM macro model: two read ports, one write port sharing
// the port-1 address. Reads are registered (1-cycle latency) and the
// outputs hold between enabled reads; a write never touches the outputs.
module sram10t_2r1w #(
  parameter int ADDR_W = sram10t_pkg::ADDR_W,
  parameter int DEPTH  = sram10t_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic              writeLine,
  input  logic              RdWr,
  input  logic              DevEn,
  output logic              readLine1,
  output logic              readLine2
);

  import sram10t_pkg::*;

  logic [DEPTH-1:0] mem;
  logic [DEPTH-1:0] sel1_p0;
  logic [DEPTH-1:0] sel2_p0;
  logic [DEPTH-1:0] wsel_p0;
  logic             rd_en_p0;
  logic             port2_en_p0;
  logic             rd1_p0;
  logic             rd2_p0;

  assign rd_en_p0    = DevEn & (RdWr == MODE_READ);
  assign port2_en_p0 = DevEn & RdWr;

  // Port 1 decoder, shared between read and write
  sram10t_decoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec1 (
    .en   (DevEn),
    .addr (addr1),
    .sel  (sel1_p0)
  );

  // Port 2 decoder, only active on reads since port 2 never writes
  sram10t_decoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec2 (
    .en   (port2_en_p0),
    .addr (addr2),
    .sel  (sel2_p0)
  );

  // Write word lines: port-1 select qualified by write mode
  assign wsel_p0 = sel1_p0 & {DEPTH{RdWr == MODE_WRITE}};

  // One-hot AND-OR read muxes; an all-zero select yields 0
  assign rd1_p0 = |(mem & sel1_p0);
  assign rd2_p0 = |(mem & sel2_p0);

  // Cell array: async clear, selected cell takes writeLine on a write edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem <= '0;
    else     mem <= (mem & ~wsel_p0) | (wsel_p0 & {DEPTH{writeLine}});
  end

  // ---- stage p0 -> p1: registered read outputs, held unless reading ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readLine1 <= 1'b0;
      readLine2 <= 1'b0;
    end else if (rd_en_p0) begin
      readLine1 <= rd1_p0;
      readLine2 <= rd2_p0;
    end
  end

endmodule

// File: tb/tb_sram10t_2r1w.sv
// Self-checking bench for sram10t_2r1w: directed scenarios plus a random
// read/write mix, all checked against a plain array model of the macro.
module tb_sram10t_2r1w;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] addr1 = '0;
  logic [11:0] addr2 = '0;
  logic        writeLine = 1'b0;
  logic        RdWr = 1'b1;
  logic        DevEn = 1'b0;
  logic        readLine1;
  logic        readLine2;

  int n_cmp = 0;
  int n_err = 0;

  bit model [4096];
  bit e1, e2;

  sram10t_2r1w dut (
    .clk       (clk),
    .rst       (rst),
    .addr1     (addr1),
    .addr2     (addr2),
    .writeLine (writeLine),
    .RdWr      (RdWr),
    .DevEn     (DevEn),
    .readLine1 (readLine1),
    .readLine2 (readLine2)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) model[i] = 1'b0;
    e1 = 1'b0;
    e2 = 1'b0;
  endtask

  // Drive one access on the falling edge, let the rising edge take it,
  // then advance the model the way the macro is described to behave.
  task automatic step(input logic en, input logic rw, input logic [11:0] a1,
                      input logic [11:0] a2, input logic wl);
    @(negedge clk);
    DevEn = en; RdWr = rw; addr1 = a1; addr2 = a2; writeLine = wl;
    @(posedge clk);
    #1;
    if (!rst && en) begin
      if (rw) begin
        e1 = model[a1];
        e2 = model[a2];
      end else begin
        model[a1] = wl;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({readLine1, readLine2} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: got %b%b want 00", i, readLine1, readLine2);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 12'd0, 12'd4095, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_read0_4095: got %b%b want 00", readLine1, readLine2);
    end
    step(1'b1, 1'b1, 12'd4095, 12'd0, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_read4095_0: got %b%b want 00", readLine1, readLine2);
    end
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    for (int a = 0; a < 4096; a++) begin
      step(1'b0, 1'b1, 12'(a), 12'(4095 - a), 1'($urandom));
      if ({readLine1, readLine2} !== 2'b00) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle_hold_outputs: %0d nonzero cycles want 0", bad);
    end
    // a few idle "writes" with RdWr low must not reach the array either
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 12'(i * 500), 12'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 12'(i * 500), 12'(i * 500 + 1), 1'b0);
      n_cmp++;
      if ({readLine1, readLine2} !== 2'b00) begin
        n_err++;
        $display("FAIL idle_array_a%0d: got %b%b want 00", i * 500, readLine1, readLine2);
      end
    end
  endtask

  task automatic test_single_write();
    step(1'b1, 1'b0, 12'd123, 12'd7, 1'b1);
    step(1'b1, 1'b1, 12'd123, 12'd123, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b11) begin
      n_err++;
      $display("FAIL single_rd123: got %b%b want 11", readLine1, readLine2);
    end
    step(1'b1, 1'b1, 12'd122, 12'd124, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL single_rd122_124: got %b%b want 00", readLine1, readLine2);
    end
    step(1'b1, 1'b1, 12'd124, 12'd123, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b01) begin
      n_err++;
      $display("FAIL single_rd124_123: got %b%b want 01", readLine1, readLine2);
    end
  endtask

  task automatic test_full_pattern();
    int bad = 0;
    for (int a = 0; a < 4096; a++) step(1'b1, 1'b0, 12'(a), 12'(~a), 1'(a % 2));
    for (int a = 0; a < 4096; a++) begin
      step(1'b1, 1'b1, 12'(a), 12'((a + 1) % 4096), 1'b0);
      if (readLine1 !== 1'(a % 2) || readLine2 !== 1'(((a + 1) % 4096) % 2)) begin
        bad++;
        if (bad <= 4)
          $display("FAIL full_pattern a=%0d: got %b%b want %b%b", a, readLine1, readLine2,
                   1'(a % 2), 1'(((a + 1) % 4096) % 2));
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL full_pattern_total: %0d bad reads want 0", bad);
    end
    // last read was a=4095, addr2 wrapped to 0
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b10) begin
      n_err++;
      $display("FAIL full_pattern_wrap: got %b%b want 10", readLine1, readLine2);
    end
  endtask

  task automatic test_write_hold();
    step(1'b1, 1'b1, 12'd1, 12'd1, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b11) begin
      n_err++;
      $display("FAIL wh_read1: got %b%b want 11", readLine1, readLine2);
    end
    step(1'b1, 1'b0, 12'd1, 12'd1, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b11) begin
      n_err++;
      $display("FAIL wh_during_write: got %b%b want 11", readLine1, readLine2);
    end
    step(1'b1, 1'b1, 12'd1, 12'd1, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL wh_after_write: got %b%b want 00", readLine1, readLine2);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    logic en, rw, wl;
    logic [11:0] a1, a2;
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      rw = $urandom_range(0, 1);
      wl = $urandom_range(0, 1);
      if (i % 2 == 0) begin
        a1 = 12'($urandom_range(0, 15));
        a2 = 12'($urandom_range(0, 15));
      end else begin
        a1 = 12'($urandom);
        a2 = 12'($urandom);
      end
      step(en, rw, a1, a2, wl);
      if ({readLine1, readLine2} !== {e1, e2}) begin
        bad++;
        if (bad <= 4)
          $display("FAIL random i=%0d: got %b%b want %b%b", i, readLine1, readLine2, e1, e2);
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL random_total: %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < 4096; a++) model[a] = 1'(a % 2);
    for (int a = 0; a < 4096; a++) step(1'b1, 1'b0, 12'(a), 12'd0, 1'(a % 2));
    step(1'b1, 1'b1, 12'd4095, 12'd3, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b11) begin
      n_err++;
      $display("FAIL rm_pre: got %b%b want 11", readLine1, readLine2);
    end
    // write of 1 to addr 4 in flight when reset hits between edges
    @(negedge clk);
    DevEn = 1'b1; RdWr = 1'b0; addr1 = 12'd4; writeLine = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL rm_immediate: got %b%b want 00", readLine1, readLine2);
    end
    @(posedge clk);
    @(negedge clk);
    DevEn = 1'b0;
    rst = 1'b0;
    step(1'b1, 1'b1, 12'd1, 12'd4095, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL rm_read1_4095: got %b%b want 00", readLine1, readLine2);
    end
    step(1'b1, 1'b1, 12'd4, 12'd4, 1'b0);
    n_cmp++;
    if ({readLine1, readLine2} !== 2'b00) begin
      n_err++;
      $display("FAIL rm_lost_write: got %b%b want 00", readLine1, readLine2);
    end
  endtask

  initial begin
    model_clear();
    #1;
    test_reset();
    test_idle_hold();
    test_single_write();
    test_full_pattern();
    test_write_hold();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
